mem_arbiter: RTL and testbench

- Shares the single pipelined 16-bit main memory between the I-cache fill FSM, the D-cache fill FSM and D-cache write-through stores.
- Grants one requester at a time and generates the 8-beat block-read address stream.
- Counts returning beats and routes each valid beat to the granted cache with its word index.
- Sits between both cache controllers and the memory model; it is the single owner of the memory address/enable/write pins.

---
 rtl/mem_arbiter_pkg.sv | 25 ++
 rtl/mem_arbiter_beat_counter.sv | 35 +++
 rtl/mem_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_arbiter_pkg                                                            |
// | Shared memory-arbiter constants, state encodings and block-base helper.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package mem_arbiter_pkg;

    localparam int c_ADDR_W = 16;
    localparam int c_BEATS  = 8;
    localparam int c_OFS_W  = 3;
    localparam int c_CNT_W  = 4;

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_IFILL  = 2'd1;
    localparam logic [1:0] c_ST_DFILL  = 2'd2;
    localparam logic [1:0] c_ST_DWRITE = 2'd3;

    // A block spans BEATS 16-bit words, i.e. the low OFS_W+1 byte-address bits.
    function automatic logic [c_ADDR_W-1:0] block_base(input logic [c_ADDR_W-1:0] addr);
        return addr & {{(c_ADDR_W-c_OFS_W-1){1'b1}}, {(c_OFS_W+1){1'b0}}};
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_beat_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_arbiter_beat_counter                                                   |
// | Up-counter with increment enable, synchronous clear and saturation.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mem_arbiter_beat_counter
    import mem_arbiter_pkg::*;
#(
    parameter int WIDTH = c_CNT_W,
    parameter int LIMIT = c_BEATS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    localparam logic [WIDTH-1:0] c_LIMIT = WIDTH'(LIMIT);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst_n || i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != c_LIMIT)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_arbiter                                                                |
// | Shares main memory between I-fill, D-fill and D write-through traffic.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int MEM_LAT = 4,
    parameter int BEATS   = c_BEATS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ic_req,
    input  logic [15:0] ic_addr,
    input  logic        dc_req,
    input  logic [15:0] dc_addr,
    input  logic        dc_wr_req,
    input  logic [15:0] dc_wr_addr,
    input  logic [15:0] dc_wr_data,
    input  logic        mem_data_valid,
    output logic [15:0] mem_addr,
    output logic        mem_enable,
    output logic        mem_wr,
    output logic [15:0] mem_wdata,
    output logic        ic_grant,
    output logic        dc_grant,
    output logic        ic_beat_valid,
    output logic        dc_beat_valid,
    output logic [2:0]  beat_idx,
    output logic        ic_fill_done,
    output logic        dc_fill_done,
    output logic        dc_wr_done
);

    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(BEATS);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(BEATS - 1);

    // Latency is a property of the memory; beats are counted, never timed.
    if (MEM_LAT < 1) begin : g_lat_unsupported
    end

    logic [1:0]          r_state;
    logic [1:0]          w_next_state;
    logic [15:0]         r_base;
    logic [15:0]         w_next_base;
    logic [c_CNT_W-1:0]  w_issue_cnt;
    logic [c_CNT_W-1:0]  w_beat_cnt;
    logic                w_in_fill;
    logic                w_issuing;
    logic                w_beat_valid;
    logic                w_fill_done;
    logic                w_pick;
    logic                w_cnt_clr;
    logic                w_write;

    always_comb begin
        w_in_fill    = (r_state == c_ST_IFILL) || (r_state == c_ST_DFILL);
        w_write      = (r_state == c_ST_DWRITE);
        w_issuing    = w_in_fill && (w_issue_cnt < c_FULL);
        w_beat_valid = w_in_fill && mem_data_valid;
        w_fill_done  = w_beat_valid && (w_beat_cnt == c_LAST);
        w_pick       = (r_state == c_ST_IDLE) || w_write || w_fill_done;
        w_cnt_clr    = !w_in_fill || w_fill_done;

        w_next_state = r_state;
        w_next_base  = r_base;
        if (w_pick) begin
            if (dc_req) begin
                w_next_state = c_ST_DFILL;
                w_next_base  = block_base(dc_addr);
            end else if (dc_wr_req) begin
                w_next_state = c_ST_DWRITE;
            end else if (ic_req) begin
                w_next_state = c_ST_IFILL;
                w_next_base  = block_base(ic_addr);
            end else begin
                w_next_state = c_ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
            r_base  <= '0;
        end else begin
            r_state <= w_next_state;
            r_base  <= w_next_base;
        end
    end

    mem_arbiter_beat_counter #(
        .WIDTH (c_CNT_W),
        .LIMIT (BEATS)
    ) u_issue_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (w_cnt_clr),
        .i_inc   (w_issuing),
        .o_count (w_issue_cnt)
    );

    mem_arbiter_beat_counter #(
        .WIDTH (c_CNT_W),
        .LIMIT (BEATS)
    ) u_beat_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (w_cnt_clr),
        .i_inc   (w_beat_valid),
        .o_count (w_beat_cnt)
    );

    always_comb begin
        mem_addr = '0;
        if (w_issuing) begin
            mem_addr = r_base | {{(c_ADDR_W-c_OFS_W-1){1'b0}}, w_issue_cnt[c_OFS_W-1:0], 1'b0};
        end else if (w_write) begin
            mem_addr = dc_wr_addr;
        end
    end

    assign mem_enable    = w_issuing || w_write;
    assign mem_wr        = w_write;
    assign mem_wdata     = w_write ? dc_wr_data : '0;
    assign ic_grant      = (r_state == c_ST_IFILL);
    assign dc_grant      = (r_state == c_ST_DFILL) || w_write;
    assign ic_beat_valid = w_beat_valid && (r_state == c_ST_IFILL);
    assign dc_beat_valid = w_beat_valid && (r_state == c_ST_DFILL);
    assign beat_idx      = w_beat_valid ? w_beat_cnt[c_OFS_W-1:0] : '0;
    assign ic_fill_done  = w_fill_done && (r_state == c_ST_IFILL);
    assign dc_fill_done  = w_fill_done && (r_state == c_ST_DFILL);
    assign dc_wr_done    = w_write;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mem_arbiter                                                             |
// | Directed and randomized bench for mem_arbiter with a fixed-latency memory. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_mem_arbiter;

    localparam int MEM_LAT = 4;
    localparam int BEATS   = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ic_req = 1'b0, dc_req = 1'b0, dc_wr_req = 1'b0, mem_data_valid = 1'b0;
    logic [15:0] ic_addr = '0, dc_addr = '0, dc_wr_addr = '0, dc_wr_data = '0;
    logic [15:0] mem_addr, mem_wdata;
    logic        mem_enable, mem_wr, ic_grant, dc_grant, ic_beat_valid, dc_beat_valid;
    logic        ic_fill_done, dc_fill_done, dc_wr_done;
    logic [2:0]  beat_idx;

    mem_arbiter #(.MEM_LAT(MEM_LAT), .BEATS(BEATS)) dut (
        .clk(clk), .rst_n(rst_n),
        .ic_req(ic_req), .ic_addr(ic_addr),
        .dc_req(dc_req), .dc_addr(dc_addr),
        .dc_wr_req(dc_wr_req), .dc_wr_addr(dc_wr_addr), .dc_wr_data(dc_wr_data),
        .mem_data_valid(mem_data_valid),
        .mem_addr(mem_addr), .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
        .ic_grant(ic_grant), .dc_grant(dc_grant),
        .ic_beat_valid(ic_beat_valid), .dc_beat_valid(dc_beat_valid), .beat_idx(beat_idx),
        .ic_fill_done(ic_fill_done), .dc_fill_done(dc_fill_done), .dc_wr_done(dc_wr_done)
    );

    always #5 clk = ~clk;

    logic [43:0] act_vec;
    logic [43:0] exp_vec;
    assign act_vec = {mem_addr, mem_enable, mem_wr, mem_wdata, ic_grant, dc_grant,
                      ic_beat_valid, dc_beat_valid, beat_idx, ic_fill_done, dc_fill_done, dc_wr_done};

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int ret_q[$];
    logic stray = 1'b0;

    // Reference: who owns memory, how many words were requested and returned.
    int          m_owner = 0;   // 0 none, 1 I-fill, 2 D-fill, 3 D-write
    logic [15:0] m_base  = '0;
    int          m_issued = 0;
    int          m_got    = 0;

    task automatic model_advance();
        bit pick;
        if (!rst_n) begin
            m_owner = 0; m_issued = 0; m_got = 0;
            return;
        end
        pick = (m_owner == 0) || (m_owner == 3);
        if (m_owner == 1 || m_owner == 2) begin
            if (mem_data_valid && m_got == BEATS - 1) pick = 1;
            else begin
                if (m_issued < BEATS) m_issued++;
                if (mem_data_valid) m_got++;
            end
        end
        if (pick) begin
            m_issued = 0; m_got = 0;
            if (dc_req) begin m_owner = 2; m_base = dc_addr & 16'hFFF0; end
            else if (dc_wr_req) m_owner = 3;
            else if (ic_req) begin m_owner = 1; m_base = ic_addr & 16'hFFF0; end
            else m_owner = 0;
        end
    endtask

    task automatic model_outputs();
        logic [15:0] a, wd;
        logic en, wr, ig, dg, ibv, dbv, ifd, dfd, wdn;
        logic [2:0] idx;
        a = '0; wd = '0; en = 0; wr = 0; ig = 0; dg = 0;
        ibv = 0; dbv = 0; ifd = 0; dfd = 0; wdn = 0; idx = '0;
        if (m_owner == 1 || m_owner == 2) begin
            ig = (m_owner == 1);
            dg = (m_owner == 2);
            if (m_issued < BEATS) begin en = 1; a = m_base + 16'(2 * m_issued); end
            if (mem_data_valid) begin
                idx = 3'(m_got);
                ibv = ig; dbv = dg;
                if (m_got == BEATS - 1) begin ifd = ig; dfd = dg; end
            end
        end else if (m_owner == 3) begin
            en = 1; wr = 1; a = dc_wr_addr; wd = dc_wr_data; dg = 1; wdn = 1;
        end
        exp_vec = {a, en, wr, wd, ig, dg, ibv, dbv, idx, ifd, dfd, wdn};
    endtask

    // One clock: inputs settle before the edge, outputs are sampled on the falling edge.
    task automatic tick();
        model_advance();
        @(posedge clk);
        #1;
        cyc++;
        mem_data_valid = stray;
        if (ret_q.size() > 0 && ret_q[0] == cyc) begin
            mem_data_valid = 1'b1;
            void'(ret_q.pop_front());
        end
        @(negedge clk);
        model_outputs();
        if (mem_enable === 1'b1 && mem_wr === 1'b0) ret_q.push_back(cyc + MEM_LAT);
    endtask

    task automatic drain();
        for (int t = 0; t < 20 && ret_q.size() > 0; t++) tick();
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        n_checks++; if (act_vec !== '0) $display("FAIL reset_outputs: got %h want 0", act_vec); else n_pass++;
    endtask

    task automatic test_ifill_alone();
        int n_iss = 0, n_beat = 0, first = -1;
        bit done = 0;
        ic_addr = 16'h1234; ic_req = 1'b1;
        for (int t = 0; t < 40 && !done; t++) begin
            tick();
            if (mem_enable) begin
                if (first < 0) first = cyc;
                n_checks++;
                if (mem_addr !== 16'h1230 + 16'(2 * n_iss) || mem_wr !== 1'b0 || cyc != first + n_iss)
                    $display("FAIL ifill_addr[%0d]: got %h wr=%b cyc=%0d want %h cyc=%0d", n_iss, mem_addr, mem_wr, cyc, 16'h1230 + 16'(2 * n_iss), first + n_iss);
                else n_pass++;
                n_iss++;
            end
            if (ic_beat_valid) begin
                n_checks++; if (beat_idx !== 3'(n_beat)) $display("FAIL ifill_beat_idx: got %0d want %0d", beat_idx, n_beat); else n_pass++;
                n_beat++;
            end
            if (ic_fill_done) begin
                done = 1; ic_req = 1'b0;
                n_checks++; if (n_beat != 8) $display("FAIL ifill_done_beat: got beat %0d want 8", n_beat); else n_pass++;
            end
        end
        n_checks++; if (!done || n_iss != 8) $display("FAIL ifill_complete: done=%0d issued=%0d want done=1 issued=8", done, n_iss); else n_pass++;
        tick();
        n_checks++; if (act_vec !== '0) $display("FAIL ifill_idle_after: got %h want 0", act_vec); else n_pass++;
        drain();
    endtask

    task automatic test_priority();
        int nd = 0, ni = 0, ic_early = 0;
        bit dc_done = 0, ic_done = 0;
        dc_addr = 16'hA0F6; ic_addr = 16'h5558; dc_req = 1'b1; ic_req = 1'b1;
        for (int t = 0; t < 40 && !dc_done; t++) begin
            tick();
            if (ic_grant) ic_early++;
            if (mem_enable && dc_grant) begin
                n_checks++; if (mem_addr !== 16'hA0F0 + 16'(2 * nd)) $display("FAIL prio_dfill_addr[%0d]: got %h want %h", nd, mem_addr, 16'hA0F0 + 16'(2 * nd)); else n_pass++;
                nd++;
            end
            if (dc_fill_done) begin dc_done = 1; dc_req = 1'b0; end
        end
        n_checks++; if (!dc_done || nd != 8 || ic_early != 0) $display("FAIL prio_dfill_first: done=%0d issued=%0d ic_grants=%0d want 1/8/0", dc_done, nd, ic_early); else n_pass++;
        tick();
        n_checks++; if ({ic_grant, mem_enable, mem_addr} !== {2'b11, 16'h5550}) $display("FAIL b2b_no_bubble: got grant=%b en=%b addr=%h want 1 1 5550", ic_grant, mem_enable, mem_addr); else n_pass++;
        ni = 1;
        for (int t = 0; t < 40 && !ic_done; t++) begin
            tick();
            if (mem_enable && ic_grant) begin
                n_checks++; if (mem_addr !== 16'h5550 + 16'(2 * ni)) $display("FAIL b2b_ifill_addr[%0d]: got %h want %h", ni, mem_addr, 16'h5550 + 16'(2 * ni)); else n_pass++;
                ni++;
            end
            if (ic_fill_done) begin ic_done = 1; ic_req = 1'b0; end
        end
        n_checks++; if (!ic_done || ni != 8) $display("FAIL b2b_ifill_complete: done=%0d issued=%0d want 1/8", ic_done, ni); else n_pass++;
        drain();
    endtask

    task automatic test_write_during_fill();
        int n_iss = 0, early_wr = 0;
        bit done = 0;
        ic_addr = 16'h3000; ic_req = 1'b1;
        for (int t = 0; t < 40 && !done; t++) begin
            tick();
            if (mem_wr) early_wr++;
            if (mem_enable && ic_grant) n_iss++;
            if (n_iss == 2 && !dc_wr_req) begin
                dc_wr_addr = 16'h0042; dc_wr_data = 16'hBEEF; dc_wr_req = 1'b1;
            end
            if (ic_fill_done) begin done = 1; ic_req = 1'b0; end
        end
        n_checks++; if (!done || early_wr != 0) $display("FAIL wr_waits_for_fill: done=%0d early_writes=%0d want 1/0", done, early_wr); else n_pass++;
        tick();
        n_checks++;
        if ({mem_enable, mem_wr, mem_addr, mem_wdata, dc_wr_done, dc_grant} !== {2'b11, 16'h0042, 16'hBEEF, 2'b11})
            $display("FAIL wr_issue: got en=%b wr=%b addr=%h data=%h done=%b grant=%b want 1 1 0042 BEEF 1 1", mem_enable, mem_wr, mem_addr, mem_wdata, dc_wr_done, dc_grant);
        else n_pass++;
        dc_wr_req = 1'b0;
        tick();
        n_checks++; if (act_vec !== '0) $display("FAIL wr_one_cycle: got %h want 0", act_vec); else n_pass++;
        drain();
    endtask

    task automatic test_req_drop();
        int n_iss = 0, n_beat = 0;
        bit done = 0;
        ic_addr = 16'h7ABC; ic_req = 1'b1;
        for (int t = 0; t < 40 && !done; t++) begin
            tick();
            if (mem_enable && ic_grant) begin
                n_checks++; if (mem_addr !== 16'h7AB0 + 16'(2 * n_iss)) $display("FAIL drop_addr[%0d]: got %h want %h", n_iss, mem_addr, 16'h7AB0 + 16'(2 * n_iss)); else n_pass++;
                n_iss++;
                if (n_iss == 3) ic_req = 1'b0;
            end
            if (ic_beat_valid) begin
                n_checks++; if (beat_idx !== 3'(n_beat)) $display("FAIL drop_beat_idx: got %0d want %0d", beat_idx, n_beat); else n_pass++;
                n_beat++;
            end
            if (ic_fill_done) done = 1;
        end
        n_checks++; if (!done || n_iss != 8 || n_beat != 8) $display("FAIL drop_completes: done=%0d issued=%0d beats=%0d want 1/8/8", done, n_iss, n_beat); else n_pass++;
        drain();
    endtask

    task automatic test_reset_mid_fill();
        int n_beat = 0, leaked = 0;
        dc_addr = 16'h4440; dc_req = 1'b1;
        for (int t = 0; t < 40 && n_beat < 5; t++) begin
            tick();
            if (dc_beat_valid) n_beat++;
        end
        rst_n = 1'b0; dc_req = 1'b0;
        tick();
        n_checks++; if (act_vec !== '0) $display("FAIL rst_mid_fill_idle: got %h want 0", act_vec); else n_pass++;
        rst_n = 1'b1;
        for (int t = 0; t < 8; t++) begin
            tick();
            if (ic_beat_valid || dc_beat_valid || dc_grant) leaked++;
        end
        n_checks++; if (n_beat != 5 || leaked != 0) $display("FAIL rst_inflight_ignored: beats_before=%0d leaked=%0d want 5/0", n_beat, leaked); else n_pass++;
        drain();
    endtask

    task automatic test_stray_valid();
        bit seen = 0;
        stray = 1'b1;
        for (int t = 0; t < 3; t++) begin
            tick();
            n_checks++; if (act_vec !== '0) $display("FAIL stray_idle[%0d]: got %h want 0", t, act_vec); else n_pass++;
        end
        stray = 1'b0;
        tick();
        ic_addr = 16'h0BE0; ic_req = 1'b1;
        for (int t = 0; t < 40 && !seen; t++) begin
            tick();
            if (ic_beat_valid) begin
                seen = 1;
                n_checks++; if (beat_idx !== 3'd0) $display("FAIL stray_counter_kept: got idx %0d want 0", beat_idx); else n_pass++;
            end
        end
        for (int t = 0; t < 20 && !ic_fill_done; t++) tick();
        ic_req = 1'b0;
        drain();
    endtask

    task automatic test_random();
        int bad = 0;
        for (int t = 0; t < 2000; t++) begin
            tick();
            n_checks++;
            if (act_vec !== exp_vec) begin
                bad++;
                if (bad <= 10) $display("FAIL rand_cycle%0d: got %h want %h", t, act_vec, exp_vec);
            end else n_pass++;
            if (ic_fill_done) ic_req = 1'b0;
            if (dc_fill_done) dc_req = 1'b0;
            if (dc_wr_done) dc_wr_req = 1'b0;
            if (!ic_req && $urandom_range(0, 7) == 0) begin ic_req = 1'b1; ic_addr = 16'($urandom); end
            if (!dc_req && $urandom_range(0, 11) == 0) begin dc_req = 1'b1; dc_addr = 16'($urandom); end
            if (!dc_wr_req && $urandom_range(0, 9) == 0) begin
                dc_wr_req = 1'b1; dc_wr_addr = 16'($urandom); dc_wr_data = 16'($urandom);
            end
            if (ic_req && $urandom_range(0, 63) == 0) ic_req = 1'b0;
            stray = ($urandom_range(0, 15) == 0);
            rst_n = ($urandom_range(0, 299) != 0);
        end
        rst_n = 1'b1; stray = 1'b0; ic_req = 1'b0; dc_req = 1'b0; dc_wr_req = 1'b0;
        drain();
    endtask

    initial begin
        test_reset();
        test_ifill_alone();
        test_priority();
        test_write_during_fill();
        test_req_drop();
        test_reset_mid_fill();
        test_stray_valid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
